// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program-counter fetch FSM with a single outstanding imem request
// Optional PC_ALIGN_CHECK_EN: misaligned redirects halt the fetcher instead of being truncated.
module pc_fetch #(
  parameter int ADDR_W   = 32,
  parameter int INSTR_W  = 32,
  parameter int OFFSET_W = 9,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                skip_valid,
  input  logic [OFFSET_W-1:0] skip_off,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_addr,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                instr_valid,
  output logic [INSTR_W-1:0]  instr,
  output logic [ADDR_W-1:0]   instr_pc,
  input  logic                instr_ready,
  output logic                misalign
);

  localparam int BYTES = INSTR_W / 8;
  localparam int SH    = $clog2(BYTES);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(BYTES);

  typedef enum logic [1:0] {FETCH, HOLD, DROP, HALT} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q, pc_pending_q, instr_pc_q;
  logic [INSTR_W-1:0]  instr_q;
  logic                instr_valid_q, misalign_q;

  logic [ADDR_W-1:0]   redir_tgt_d, skip_step_d, pc_next_d;
  logic                redir_bad_d;

  always_comb begin
    redir_tgt_d = redirect_addr & ~LOW_MASK;
`ifdef PC_ALIGN_CHECK_EN
    redir_bad_d = |(redirect_addr & LOW_MASK);
`else
    redir_bad_d = 1'b0;
`endif
    // Offset counts instructions, so sign-extend to address width before scaling to bytes.
    skip_step_d = ADDR_W'($signed(skip_off)) << SH;
    pc_next_d   = pc_q + STEP;
    if (skip_valid && (skip_off != '0)) begin
      pc_next_d = pc_q + skip_step_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_VEC;
      pc_pending_q  <= RESET_VEC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (redirect_valid) begin
            if (redir_bad_d) begin
              misalign_q    <= 1'b1;
              instr_valid_q <= 1'b0;
              state_q       <= HALT;
            end else if (imem_ack) begin
              pc_q <= redir_tgt_d;
            end else begin
              pc_pending_q <= redir_tgt_d;
              state_q      <= DROP;
            end
          end else if (imem_ack) begin
            instr_q       <= imem_rdata;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            instr_valid_q <= 1'b0;
            if (redir_bad_d) begin
              misalign_q <= 1'b1;
              state_q    <= HALT;
            end else begin
              pc_q    <= redir_tgt_d;
              state_q <= FETCH;
            end
          end else if (instr_ready) begin
            instr_valid_q <= 1'b0;
            pc_q          <= pc_next_d;
            state_q       <= FETCH;
          end
        end
        DROP: begin
          // The in-flight request keeps its old address; only the ack matters here.
          if (redirect_valid) begin
            if (redir_bad_d) begin
              misalign_q    <= 1'b1;
              instr_valid_q <= 1'b0;
              state_q       <= HALT;
            end else begin
              pc_pending_q <= redir_tgt_d;
              if (imem_ack) begin
                pc_q    <= redir_tgt_d;
                state_q <= FETCH;
              end
            end
          end else if (imem_ack) begin
            pc_q    <= pc_pending_q;
            state_q <= FETCH;
          end
        end
        default: begin
          state_q       <= HALT;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == DROP);
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign misalign    = misalign_q;

endmodule
